instr_sequencer_fsm: RTL and testbench

- Parametrised instruction-sequencing FSM for the core's control path, sitting between the fetch/MMU port and the execute unit.
- Owns pc, the current instruction word, the instruction code and the retired-instruction count.
- Successor to the fixed-width sequencer. Adds:
  - parametrised widths and reset vector
  - an execute-busy stall
  - trap-cause reporting
  - selectable illegal-instruction policy
  - an optional interrupt wake from sleep

---
 rtl/instr_sequencer_fsm.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_instr_sequencer_fsm.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer_fsm
//  Purpose  : Instruction-sequencing FSM between the fetch/MMU port and the
//             execute unit. Owns pc, the current instruction word and code,
//             the retired-instruction count and the last trap cause.
//  Ports    : clock, reset (async, active-high), clock_enable, mem_ready,
//             exec_busy, decode flags (is_sleep, is_illegal, is_load_store,
//             is_branch_taken, is_fence), trap sources (exception_triggered,
//             step_trap, irq_pending), trap_vector, target_address, next_pc,
//             fetch_data, fetch_code, cycle_count
//             -> pc, inst, inst_code, inst_count, retire, state_o, trap_cause
//  Options  : ISEQ_WFI_WAKE_EN - when defined, irq_pending wakes SLEEP into
//             TRAP with cause 5; otherwise SLEEP is terminal until reset.
//  Revision : 1.0 - initial parametrised sequencer
// ============================================================================
module instr_sequencer_fsm #(
    parameter int                PC_W         = 36,
    parameter int                FETCH_W      = 64,
    parameter int                INST_W       = 32,
    parameter int                INST_BYTES   = 4,
    parameter logic [PC_W-1:0]   RESET_VECTOR = 36'h4_0000_0000,
    parameter logic [INST_W-1:0] NOP_INST     = 32'h0000_0013,
    parameter int                BOOT_WAIT    = 2,
    parameter bit                ILLEGAL_TRAP = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clock_enable,
    input  logic               mem_ready,
    input  logic               exec_busy,
    input  logic               is_sleep,
    input  logic               is_illegal,
    input  logic               is_load_store,
    input  logic               is_branch_taken,
    input  logic               is_fence,
    input  logic               exception_triggered,
    input  logic               step_trap,
    input  logic               irq_pending,
    input  logic [PC_W-1:0]    trap_vector,
    input  logic [PC_W-1:0]    target_address,
    input  logic [PC_W-1:0]    next_pc,
    input  logic [FETCH_W-1:0] fetch_data,
    input  logic [15:0]        fetch_code,
    input  logic [63:0]        cycle_count,
    output logic [PC_W-1:0]    pc,
    output logic [INST_W-1:0]  inst,
    output logic [15:0]        inst_code,
    output logic [31:0]        inst_count,
    output logic               retire,
    output logic [3:0]         state_o,
    output logic [2:0]         trap_cause
);

    typedef enum logic [3:0] {
        ST_BOOT   = 4'd0,
        ST_PRE    = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM    = 4'd3,
        ST_BRANCH = 4'd4,
        ST_TRAP   = 4'd5,
        ST_FENCE  = 4'd6,
        ST_SLEEP  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    localparam logic [2:0] CAUSE_EXCEPTION = 3'd1;
    localparam logic [2:0] CAUSE_ILLEGAL   = 3'd2;
    localparam logic [2:0] CAUSE_STEP      = 3'd3;
    localparam logic [2:0] CAUSE_IRQ       = 3'd4;
    localparam logic [2:0] CAUSE_WAKE      = 3'd5;

    localparam logic [PC_W-1:0] PC_INC = PC_W'(INST_BYTES);

    state_t              state, next_state, base_next;
    logic [2:0]          next_cause, base_cause;
    logic                advance;
    logic [INST_W-1:0]   fetch_inst;
    logic [INST_W-1:0]   hold;
    logic [15:0]         hold_code;

    state_t              state_d;
    logic [PC_W-1:0]     pc_d;
    logic [INST_W-1:0]   inst_d, hold_d;
    logic [15:0]         inst_code_d, hold_code_d;
    logic [31:0]         inst_count_d;
    logic                retire_d;
    logic [2:0]          trap_cause_d;

    // The instruction sits in the top bits of the fetch word; only that slice
    // is ever used, so the low bits are explicitly parked.
    assign fetch_inst = fetch_data[FETCH_W-1 -: INST_W];

    generate
        if (FETCH_W > INST_W) begin : g_fetch_low
            logic unused_fetch_low;
            assign unused_fetch_low = ^fetch_data[FETCH_W-INST_W-1:0];
        end
    endgenerate

    assign state_o = state;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        advance = clock_enable && mem_ready;
        if ((state == ST_BOOT) && (cycle_count < 64'(BOOT_WAIT))) begin
            advance = 1'b0;
        end
        // A busy execute unit only stalls the EXEC state.
        if ((state == ST_EXEC) && exec_busy) begin
            advance = 1'b0;
        end

        base_next  = state;
        base_cause = 3'd0;
        case (state)
            ST_BOOT:   base_next = ST_PRE;
            ST_PRE:    base_next = ST_EXEC;
            ST_EXEC: begin
                if (is_sleep) begin
                    base_next = ST_SLEEP;
                end else if (is_illegal) begin
                    if (ILLEGAL_TRAP) begin
                        base_next  = ST_TRAP;
                        base_cause = CAUSE_ILLEGAL;
                    end else begin
                        base_next = ST_HALT;
                    end
                end else if (is_load_store) begin
                    base_next = ST_MEM;
                end else if (is_branch_taken) begin
                    base_next = ST_BRANCH;
                end else begin
                    base_next = ST_EXEC;
                end
            end
            ST_MEM: begin
                if (is_fence) begin
                    base_next = ST_FENCE;
                end else if (is_branch_taken) begin
                    base_next = ST_BRANCH;
                end else begin
                    base_next = ST_EXEC;
                end
            end
            ST_BRANCH: base_next = ST_EXEC;
            ST_TRAP:   base_next = ST_PRE;
            ST_FENCE:  base_next = ST_PRE;
            ST_SLEEP: begin
`ifdef ISEQ_WFI_WAKE_EN
                if (irq_pending) begin
                    base_next  = ST_TRAP;
                    base_cause = CAUSE_WAKE;
                end else begin
                    base_next = ST_SLEEP;
                end
`else
                base_next = ST_SLEEP;
`endif
            end
            ST_HALT:   base_next = ST_HALT;
            default:   base_next = ST_HALT;
        endcase

        // Synchronous exceptions win; step/irq only intercept a transition
        // that would otherwise start a new instruction.
        next_state = base_next;
        next_cause = base_cause;
        if (exception_triggered &&
            ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_BRANCH))) begin
            next_state = ST_TRAP;
            next_cause = CAUSE_EXCEPTION;
        end else if (base_next == ST_EXEC) begin
            if (step_trap) begin
                next_state = ST_TRAP;
                next_cause = CAUSE_STEP;
            end else if (irq_pending) begin
                next_state = ST_TRAP;
                next_cause = CAUSE_IRQ;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        inst_d       = inst;
        inst_code_d  = inst_code;
        inst_count_d = inst_count;
        retire_d     = retire;
        trap_cause_d = trap_cause;
        hold_d       = hold;
        hold_code_d  = hold_code;

        if (clock_enable) begin
            retire_d = 1'b0;
        end

        if (advance) begin
            state_d = next_state;

            // Capture the word fetched alongside a load/store so it can be
            // issued once the memory phase completes.
            if ((next_state == ST_MEM) || (state == ST_EXEC)) begin
                hold_d      = fetch_inst;
                hold_code_d = fetch_code;
            end

            case (next_state)
                ST_PRE: begin
                    pc_d = pc + PC_INC;
                    if (state == ST_BOOT) begin
                        inst_d      = NOP_INST;
                        inst_code_d = 16'd0;
                    end
                end
                ST_EXEC: begin
                    pc_d = pc + PC_INC;
                    if (state == ST_MEM) begin
                        inst_d      = hold;
                        inst_code_d = hold_code;
                    end else begin
                        inst_d      = fetch_inst;
                        inst_code_d = fetch_code;
                    end
                    inst_count_d = inst_count + 32'd1;
                    retire_d     = 1'b1;
                end
                ST_BRANCH: begin
                    pc_d = target_address + PC_INC;
                end
                ST_TRAP: begin
                    pc_d         = trap_vector;
                    inst_d       = NOP_INST;
                    inst_code_d  = 16'd0;
                    trap_cause_d = next_cause;
                end
                ST_FENCE: begin
                    pc_d        = next_pc;
                    inst_d      = NOP_INST;
                    inst_code_d = 16'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_BOOT;
            pc         <= RESET_VECTOR;
            inst       <= NOP_INST;
            inst_code  <= 16'd0;
            inst_count <= 32'd0;
            retire     <= 1'b0;
            trap_cause <= 3'd0;
            hold       <= '0;
            hold_code  <= 16'd0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            inst       <= inst_d;
            inst_code  <= inst_code_d;
            inst_count <= inst_count_d;
            retire     <= retire_d;
            trap_cause <= trap_cause_d;
            hold       <= hold_d;
            hold_code  <= hold_code_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer_fsm
//  Purpose  : Self-checking bench for instr_sequencer_fsm. A table of
//             stimulus/expected records walks the sequencer through boot,
//             straight-line, stall, load, branch, trap, fence and sleep;
//             hand-built records then cover reset mid-run and pc wrap. A
//             second instance with ILLEGAL_TRAP=0 checks the HALT policy.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_instr_sequencer_fsm;

    localparam logic [10:0] F_CE   = 11'h400;
    localparam logic [10:0] F_MR   = 11'h200;
    localparam logic [10:0] F_BUSY = 11'h100;
    localparam logic [10:0] F_SLP  = 11'h080;
    localparam logic [10:0] F_ILL  = 11'h040;
    localparam logic [10:0] F_LS   = 11'h020;
    localparam logic [10:0] F_BR   = 11'h010;
    localparam logic [10:0] F_FEN  = 11'h008;
    localparam logic [10:0] F_EXC  = 11'h004;
    localparam logic [10:0] F_STP  = 11'h002;
    localparam logic [10:0] F_IRQ  = 11'h001;
    localparam logic [10:0] GO     = F_CE | F_MR;

    localparam logic [35:0] RV  = 36'h4_0000_0000;
    localparam logic [35:0] TV  = 36'h4_0000_0800;
    localparam logic [35:0] TGT = 36'h4_0000_0100;
    localparam logic [63:0] D   = 64'h00A0_0093_1111_2222;
    localparam logic [63:0] H   = 64'hDEAD_BEEF_0000_0000;
    localparam logic [31:0] IA  = 32'h00A0_0093;
    localparam logic [31:0] IH  = 32'hDEAD_BEEF;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        logic [10:0] flags;
        logic [63:0] cyc;
        logic [63:0] fdata;
        logic [15:0] fcode;
        logic [35:0] target;
        logic [3:0]  e_state;
        logic [35:0] e_pc;
        logic [31:0] e_inst;
        logic [15:0] e_code;
        logic [31:0] e_cnt;
        logic        e_retire;
        logic [2:0]  e_cause;
    } vec_t;

    logic        clock, reset, clock_enable, mem_ready, exec_busy;
    logic        is_sleep, is_illegal, is_load_store, is_branch_taken, is_fence;
    logic        exception_triggered, step_trap, irq_pending;
    logic [35:0] trap_vector, target_address, next_pc;
    logic [63:0] fetch_data;
    logic [15:0] fetch_code;
    logic [63:0] cycle_count;

    logic [35:0] pc, pc_h;
    logic [31:0] inst, inst_h;
    logic [15:0] inst_code, inst_code_h;
    logic [31:0] inst_count, inst_count_h;
    logic        retire, retire_h;
    logic [3:0]  state_o, state_h;
    logic [2:0]  trap_cause, trap_cause_h;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    vec_t sb[$];

    instr_sequencer_fsm dut (
        .clock(clock), .reset(reset), .clock_enable(clock_enable),
        .mem_ready(mem_ready), .exec_busy(exec_busy),
        .is_sleep(is_sleep), .is_illegal(is_illegal),
        .is_load_store(is_load_store), .is_branch_taken(is_branch_taken),
        .is_fence(is_fence), .exception_triggered(exception_triggered),
        .step_trap(step_trap), .irq_pending(irq_pending),
        .trap_vector(trap_vector), .target_address(target_address),
        .next_pc(next_pc), .fetch_data(fetch_data), .fetch_code(fetch_code),
        .cycle_count(cycle_count), .pc(pc), .inst(inst),
        .inst_code(inst_code), .inst_count(inst_count), .retire(retire),
        .state_o(state_o), .trap_cause(trap_cause)
    );

    instr_sequencer_fsm #(.ILLEGAL_TRAP(1'b0)) dut_h (
        .clock(clock), .reset(reset), .clock_enable(clock_enable),
        .mem_ready(mem_ready), .exec_busy(exec_busy),
        .is_sleep(is_sleep), .is_illegal(is_illegal),
        .is_load_store(is_load_store), .is_branch_taken(is_branch_taken),
        .is_fence(is_fence), .exception_triggered(exception_triggered),
        .step_trap(step_trap), .irq_pending(irq_pending),
        .trap_vector(trap_vector), .target_address(target_address),
        .next_pc(next_pc), .fetch_data(fetch_data), .fetch_code(fetch_code),
        .cycle_count(cycle_count), .pc(pc_h), .inst(inst_h),
        .inst_code(inst_code_h), .inst_count(inst_count_h), .retire(retire_h),
        .state_o(state_h), .trap_cause(trap_cause_h)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    function automatic vec_t mk(input string nm, input logic [10:0] fl,
                                input logic [63:0] cy, input logic [63:0] fd,
                                input logic [15:0] fc, input logic [35:0] tg,
                                input logic [3:0] es, input logic [35:0] ep,
                                input logic [31:0] ei, input logic [15:0] ec,
                                input logic [31:0] en, input logic er,
                                input logic [2:0] ca);
        vec_t v;
        v.name = nm;   v.flags = fl;  v.cyc = cy;     v.fdata = fd;
        v.fcode = fc;  v.target = tg; v.e_state = es; v.e_pc = ep;
        v.e_inst = ei; v.e_code = ec; v.e_cnt = en;   v.e_retire = er;
        v.e_cause = ca;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".state"},  64'(state_o),    64'd0);
        chk({tag, ".pc"},     64'(pc),         64'(RV));
        chk({tag, ".inst"},   64'(inst),       64'(NOP));
        chk({tag, ".code"},   64'(inst_code),  64'd0);
        chk({tag, ".count"},  64'(inst_count), 64'd0);
        chk({tag, ".retire"}, 64'(retire),     64'd0);
        chk({tag, ".cause"},  64'(trap_cause), 64'd0);
        chk({tag, ".h_state"}, 64'(state_h),   64'd0);
    endtask

    // Drive one record at the falling edge, queue its expectation, and
    // compare it just after the following rising edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        clock_enable        = v.flags[10];
        mem_ready           = v.flags[9];
        exec_busy           = v.flags[8];
        is_sleep            = v.flags[7];
        is_illegal          = v.flags[6];
        is_load_store       = v.flags[5];
        is_branch_taken     = v.flags[4];
        is_fence            = v.flags[3];
        exception_triggered = v.flags[2];
        step_trap           = v.flags[1];
        irq_pending         = v.flags[0];
        cycle_count         = v.cyc;
        fetch_data          = v.fdata;
        fetch_code          = v.fcode;
        target_address      = v.target;
        sb.push_back(v);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({e.name, ".state"},  64'(state_o),    64'(e.e_state));
        chk({e.name, ".pc"},     64'(pc),         64'(e.e_pc));
        chk({e.name, ".inst"},   64'(inst),       64'(e.e_inst));
        chk({e.name, ".code"},   64'(inst_code),  64'(e.e_code));
        chk({e.name, ".count"},  64'(inst_count), 64'(e.e_cnt));
        chk({e.name, ".retire"}, 64'(retire),     64'(e.e_retire));
        chk({e.name, ".cause"},  64'(trap_cause), 64'(e.e_cause));
    endtask

    initial begin
        reset = 1'b1;
        clock_enable = 1'b0; mem_ready = 1'b0; exec_busy = 1'b0;
        is_sleep = 1'b0; is_illegal = 1'b0; is_load_store = 1'b0;
        is_branch_taken = 1'b0; is_fence = 1'b0; exception_triggered = 1'b0;
        step_trap = 1'b0; irq_pending = 1'b0;
        trap_vector = TV; target_address = TGT; next_pc = 36'h4_0000_0040;
        fetch_data = 64'd0; fetch_code = 16'd0; cycle_count = 64'd0;

        //          name            flags              cyc   fdata fcode tgt  st  pc               inst code   cnt ret cause
        vecs.push_back(mk("boot_c0",    GO,                  0,  D, 16'h33, TGT, 0, RV,              NOP, 16'h0,  0, 0, 0));
        vecs.push_back(mk("boot_c1",    GO,                  1,  D, 16'h33, TGT, 0, RV,              NOP, 16'h0,  0, 0, 0));
        vecs.push_back(mk("boot_nrdy",  F_CE,                5,  D, 16'h33, TGT, 0, RV,              NOP, 16'h0,  0, 0, 0));
        vecs.push_back(mk("boot_c2",    GO,                  2,  D, 16'h33, TGT, 1, 36'h4_0000_0004, NOP, 16'h0,  0, 0, 0));
        vecs.push_back(mk("pre_exec",   GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0008, IA,  16'h33, 1, 1, 0));
        vecs.push_back(mk("ce_off",     F_MR,              100,  D, 16'h33, TGT, 2, 36'h4_0000_0008, IA,  16'h33, 1, 1, 0));
        vecs.push_back(mk("straight1",  GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_000C, IA,  16'h33, 2, 1, 0));
        vecs.push_back(mk("straight2",  GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0010, IA,  16'h33, 3, 1, 0));
        vecs.push_back(mk("busy1",      GO | F_BUSY,       100,  D, 16'h33, TGT, 2, 36'h4_0000_0010, IA,  16'h33, 3, 0, 0));
        vecs.push_back(mk("busy2",      GO | F_BUSY,       100,  D, 16'h33, TGT, 2, 36'h4_0000_0010, IA,  16'h33, 3, 0, 0));
        vecs.push_back(mk("exec_nrdy",  F_CE,              100,  D, 16'h33, TGT, 2, 36'h4_0000_0010, IA,  16'h33, 3, 0, 0));
        vecs.push_back(mk("to_mem",     GO | F_LS,         100,  H, 16'h55, TGT, 3, 36'h4_0000_0010, IA,  16'h33, 3, 0, 0));
        vecs.push_back(mk("mem_exec",   GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0014, IH,  16'h55, 4, 1, 0));
        vecs.push_back(mk("to_branch",  GO | F_BR,         100,  D, 16'h33, TGT, 4, 36'h4_0000_0104, IH,  16'h55, 4, 0, 0));
        vecs.push_back(mk("br_exec",    GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0108, IA,  16'h33, 5, 1, 0));
        vecs.push_back(mk("to_mem2",    GO | F_LS,         100,  H, 16'h55, TGT, 3, 36'h4_0000_0108, IA,  16'h33, 5, 0, 0));
        vecs.push_back(mk("mem_exc",    GO | F_EXC,        100,  D, 16'h33, TGT, 5, TV,              NOP, 16'h0,  5, 0, 1));
        vecs.push_back(mk("trap_pre",   GO,                100,  D, 16'h33, TGT, 1, 36'h4_0000_0804, NOP, 16'h0,  5, 0, 1));
        vecs.push_back(mk("pre_exec2",  GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0808, IA,  16'h33, 6, 1, 1));
        vecs.push_back(mk("step_irq",   GO | F_STP | F_IRQ,100,  D, 16'h33, TGT, 5, TV,              NOP, 16'h0,  6, 0, 3));
        vecs.push_back(mk("trap_pre2",  GO,                100,  D, 16'h33, TGT, 1, 36'h4_0000_0804, NOP, 16'h0,  6, 0, 3));
        vecs.push_back(mk("pre_irq",    GO | F_IRQ,        100,  D, 16'h33, TGT, 5, TV,              NOP, 16'h0,  6, 0, 4));
        vecs.push_back(mk("trap_pre3",  GO,                100,  D, 16'h33, TGT, 1, 36'h4_0000_0804, NOP, 16'h0,  6, 0, 4));
        vecs.push_back(mk("pre_exec3",  GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0808, IA,  16'h33, 7, 1, 4));
        vecs.push_back(mk("exec_ill",   GO | F_ILL,        100,  D, 16'h33, TGT, 5, TV,              NOP, 16'h0,  7, 0, 2));
        vecs.push_back(mk("trap_pre4",  GO,                100,  D, 16'h33, TGT, 1, 36'h4_0000_0804, NOP, 16'h0,  7, 0, 2));
        vecs.push_back(mk("pre_exec4",  GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0808, IA,  16'h33, 8, 1, 2));
        vecs.push_back(mk("to_mem3",    GO | F_LS,         100,  H, 16'h55, TGT, 3, 36'h4_0000_0808, IA,  16'h33, 8, 0, 2));
        vecs.push_back(mk("mem_fence",  GO | F_FEN | F_BR, 100,  D, 16'h33, TGT, 6, 36'h4_0000_0040, NOP, 16'h0,  8, 0, 2));
        vecs.push_back(mk("fence_pre",  GO | F_IRQ,        100,  D, 16'h33, TGT, 1, 36'h4_0000_0044, NOP, 16'h0,  8, 0, 2));
        vecs.push_back(mk("pre_exec5",  GO,                100,  D, 16'h33, TGT, 2, 36'h4_0000_0048, IA,  16'h33, 9, 1, 2));
        vecs.push_back(mk("exec_sleep", GO | F_SLP | F_ILL | F_LS, 100, D, 16'h33, TGT, 7, 36'h4_0000_0048, IA, 16'h33, 9, 0, 2));
`ifdef ISEQ_WFI_WAKE_EN
        vecs.push_back(mk("sleep_wake", GO | F_IRQ,        100,  D, 16'h33, TGT, 5, TV,              NOP, 16'h0,  9, 0, 5));
`else
        vecs.push_back(mk("sleep_irq",  GO | F_IRQ,        100,  D, 16'h33, TGT, 7, 36'h4_0000_0048, IA,  16'h33, 9, 0, 2));
`endif

        // Reset values while reset is held.
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (vecs[i].name == "exec_ill") begin
                chk("halt_policy.state", 64'(state_h), 64'd8);
            end
        end

        // Illegal with ILLEGAL_TRAP=0 must be terminal: still halted, pc frozen.
        chk("halt_stuck.state", 64'(state_h), 64'd8);
        chk("halt_stuck.pc",    64'(pc_h),    64'h4_0000_0808);

`ifdef ISEQ_WFI_WAKE_EN
        apply(mk("wake_pre", GO, 100, D, 16'h33, TGT, 1, 36'h4_0000_0804, NOP, 16'h0, 9, 0, 5));
`else
        for (int k = 0; k < 100; k++) begin
            apply(mk("sleep_hold", GO | F_IRQ, 100, D, 16'h33, TGT, 7, 36'h4_0000_0048, IA, 16'h33, 9, 0, 2));
        end
`endif

        // Asynchronous reset mid-run, away from any clock edge.
        @(negedge clock);
        clock_enable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clock);
        reset = 1'b0;

        // Re-boot (cycle_count already past the wait) and wrap pc through 2^36.
        apply(mk("reboot",    GO,          100, D, 16'h33, TGT, 1, 36'h4_0000_0004, NOP, 16'h0, 0, 0, 0));
        apply(mk("reb_exec",  GO,          100, D, 16'h33, TGT, 2, 36'h4_0000_0008, IA,  16'h33, 1, 1, 0));
        apply(mk("br_top",    GO | F_BR,   100, D, 16'h33, 36'hF_FFFF_FFF8, 4, 36'hF_FFFF_FFFC, IA, 16'h33, 1, 0, 0));
        // exec_busy outside EXEC must not stall.
        apply(mk("pc_wrap",   GO | F_BUSY, 100, 64'h1234_5678_0000_0000, 16'h77, TGT, 2, 36'h0_0000_0000, 32'h1234_5678, 16'h77, 2, 1, 0));
        apply(mk("after_wrap",GO,          100, D, 16'h33, TGT, 2, 36'h0_0000_0004, IA,  16'h33, 3, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
